// File: rtl/conv_accumulator_if.sv
// Product-in / activation-out handshake bundle of the convolution accumulator.
// The master side feeds products and consumes results; the slave side is the accumulator.
`timescale 1ns/1ps
interface conv_accumulator_if #(
    parameter int PROD_WIDTH = 14,
    parameter int BIAS_WIDTH = 14,
    parameter int ACC_WIDTH  = 19,
    parameter int OUT_WIDTH  = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [PROD_WIDTH-1:0] in_data;
    logic signed [BIAS_WIDTH-1:0] bias;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic signed [ACC_WIDTH-1:0]  out_acc;
    logic                         out_sat;

    modport master (
        output in_valid, in_data, bias, out_ready,
        input  in_ready, out_valid, out_data, out_acc, out_sat
    );

    modport slave (
        input  in_valid, in_data, bias, out_ready,
        output in_ready, out_valid, out_data, out_acc, out_sat
    );
endinterface

// File: rtl/conv_accumulator.sv
// Sums one convolution window of signed products plus bias, then requantizes
// (rounding shift, optional ReLU, saturation) and holds the activation until taken.
`timescale 1ns/1ps
module conv_accumulator #(
    parameter int PROD_WIDTH  = 14,
    parameter int KERNEL_SIZE = 9,
    parameter int BIAS_WIDTH  = 14,
    parameter int ACC_WIDTH   = 19,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT       = 4,
    parameter int RELU_EN     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    conv_accumulator_if.slave   bus
);
    localparam int CNT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_SIZE - 1);
    localparam int QW = ACC_WIDTH + 1;
    localparam logic signed [QW-1:0] RND     = QW'(1) << (SHIFT - 1);
    localparam logic signed [QW-1:0] OUT_MAX = QW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [QW-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic {ACCUM, HOLD} state_t;

    typedef struct packed {
        logic                        sat;
        logic signed [OUT_WIDTH-1:0] data;
    } quant_t;

    // One guard bit keeps the rounding add from wrapping near the accumulator limit.
    function automatic logic signed [QW-1:0] round_shift(input logic signed [ACC_WIDTH-1:0] sum);
        logic signed [QW-1:0] t;
        t = {sum[ACC_WIDTH-1], sum} + RND;
        return t >>> SHIFT;
    endfunction

    function automatic quant_t saturate(input logic signed [QW-1:0] r);
        quant_t q;
        q.sat  = 1'b0;
        q.data = r[OUT_WIDTH-1:0];
        if (r > OUT_MAX) begin
            q.sat  = 1'b1;
            q.data = OUT_MAX[OUT_WIDTH-1:0];
        end else if (r < OUT_MIN) begin
            q.sat  = 1'b1;
            q.data = OUT_MIN[OUT_WIDTH-1:0];
        end
        return q;
    endfunction

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [CNT_W-1:0]             r_cnt;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  r_out_acc;
    logic signed [OUT_WIDTH-1:0]  r_out_data;
    logic                         r_out_sat;

    logic                         w_in_ready;
    logic                         w_out_valid;
    logic                         w_xfer;
    logic                         w_last;
    logic signed [ACC_WIDTH-1:0]  w_bias_ext;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
    logic signed [QW-1:0]         w_round;
    logic signed [QW-1:0]         w_relu;
    quant_t                       w_q;

    assign w_bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bus.bias[BIAS_WIDTH-1]}}, bus.bias};
    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.in_data[PROD_WIDTH-1]}}, bus.in_data};
    assign w_acc_nxt  = ((r_cnt == '0) ? w_bias_ext : r_acc) + w_prod_ext;
    assign w_xfer     = bus.in_valid & w_in_ready;
    assign w_last     = (r_cnt == LAST);

    always_comb begin
        w_round = round_shift(w_acc_nxt);
        w_relu  = w_round;
        if ((RELU_EN != 0) && (w_round < 0)) begin
            w_relu = '0;
        end
        w_q = saturate(w_relu);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs depend on the registered state only.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_ready = 1'b1;
                if (w_xfer && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (clear) begin
            w_state_nxt = ACCUM;
        end
    end

    // Accumulator and result registers; clear drops any coincident product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_out_acc  <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_xfer) begin
            r_acc <= w_acc_nxt;
            if (w_last) begin
                r_cnt      <= '0;
                r_out_acc  <= w_acc_nxt;
                r_out_data <= w_q.data;
                r_out_sat  <= w_q.sat;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_acc   = r_out_acc;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
endmodule
